mem_2_axi4_lite: RTL and testbench

- AXI4-Lite master driven by a simple memory-style request port.
- Local clients (CPU stub, DMA, test sequencer) issue single-beat reads and writes; the block converts them to AXI4-Lite transactions toward any AXI4-Lite slave, including the memory bridge.
- Independent write and read engines; one outstanding transaction per direction; busy flags provide back-pressure.

---
 rtl/mem_2_axi4_lite.sv | 256 +++++++++++++++++++++++++
 tb/tb_mem_2_axi4_lite.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_2_axi4_lite.sv
`default_nettype none
// ============================================================================
// mem_2_axi4_lite : single-beat memory request port to AXI4-Lite master,
//                   independent write and read engines, one outstanding each.
// Revision        : 1.0
// ============================================================================
module mem_2_axi4_lite #(
  parameter int ALEN = 32,
  parameter int DLEN = 32,
  parameter int SLEN = DLEN / 8
) (
  input  logic            clk,
  input  logic            rstn,
  // memory-style write request port
  input  logic            mem_wen,
  input  logic [ALEN-1:0] mem_waddr,
  input  logic [DLEN-1:0] mem_wdata,
  input  logic [SLEN-1:0] mem_wstrb,
  output logic            mem_wbusy,
  output logic            mem_wdone,
  output logic [1:0]      mem_wresp,
  // memory-style read request port
  input  logic            mem_ren,
  input  logic [ALEN-1:0] mem_raddr,
  output logic            mem_rbusy,
  output logic            mem_rvalid,
  output logic [DLEN-1:0] mem_rdata,
  output logic [1:0]      mem_rresp,
  // AXI4-Lite write address channel
  output logic            awvalid,
  input  logic            awready,
  output logic [ALEN-1:0] awaddr,
  output logic [2:0]      awprot,
  // AXI4-Lite write data channel
  output logic            wvalid,
  input  logic            wready,
  output logic [DLEN-1:0] wdata,
  output logic [SLEN-1:0] wstrb,
  // AXI4-Lite write response channel
  input  logic            bvalid,
  output logic            bready,
  input  logic [1:0]      bresp,
  // AXI4-Lite read address channel
  output logic            arvalid,
  input  logic            arready,
  output logic [ALEN-1:0] araddr,
  output logic [2:0]      arprot,
  // AXI4-Lite read data channel
  input  logic            rvalid,
  output logic            rready,
  input  logic [DLEN-1:0] rdata,
  input  logic [1:0]      rresp
);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rstate_e;

  // --------------------------------------------------------------------------
  // Write engine
  // --------------------------------------------------------------------------
  wstate_e         wstate_q,  wstate_d;
  logic [ALEN-1:0] awaddr_q,  awaddr_d;
  logic [DLEN-1:0] wdata_q,   wdata_d;
  logic [SLEN-1:0] wstrb_q,   wstrb_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q,  wvalid_d;
  logic            bready_q,  bready_d;
  logic            wbusy_q,   wbusy_d;
  logic            wdone_q,   wdone_d;
  logic [1:0]      wresp_q,   wresp_d;

  always_comb begin
    wstate_d  = wstate_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    wbusy_d   = wbusy_q;
    wdone_d   = 1'b0;
    wresp_d   = wresp_q;

    case (wstate_q)
      W_IDLE: begin
        if (mem_wen) begin
          awaddr_d  = mem_waddr;
          wdata_d   = mem_wdata;
          wstrb_d   = mem_wstrb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          wbusy_d   = 1'b1;
          wstate_d  = W_REQ;
        end
      end
      W_REQ: begin
        // AW and W retire independently; move on once neither is pending
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bvalid && bready_q) begin
          wresp_d  = bresp;
          bready_d = 1'b0;
          wdone_d  = 1'b1;
          wbusy_d  = 1'b0;
          wstate_d = W_IDLE;
        end
      end
      default: begin
        wstate_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wstate_q  <= W_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      wbusy_q   <= 1'b0;
      wdone_q   <= 1'b0;
      wresp_q   <= 2'b00;
    end else begin
      wstate_q  <= wstate_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      wbusy_q   <= wbusy_d;
      wdone_q   <= wdone_d;
      wresp_q   <= wresp_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read engine
  // --------------------------------------------------------------------------
  rstate_e         rstate_q,  rstate_d;
  logic [ALEN-1:0] araddr_q,  araddr_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q,  rready_d;
  logic            rbusy_q,   rbusy_d;
  logic            rdone_q,   rdone_d;
  logic [DLEN-1:0] rdata_q,   rdata_d;
  logic [1:0]      rresp_q,   rresp_d;

  always_comb begin
    rstate_d  = rstate_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    rbusy_d   = rbusy_q;
    rdone_d   = 1'b0;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    case (rstate_q)
      R_IDLE: begin
        if (mem_ren) begin
          araddr_d  = mem_raddr;
          arvalid_d = 1'b1;
          rbusy_d   = 1'b1;
          rstate_d  = R_ADDR;
        end
      end
      R_ADDR: begin
        if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          rstate_d  = R_DATA;
        end
      end
      R_DATA: begin
        // read data and response stay on the client port until the next read
        if (rvalid && rready_q) begin
          rdata_d  = rdata;
          rresp_d  = rresp;
          rready_d = 1'b0;
          rdone_d  = 1'b1;
          rbusy_d  = 1'b0;
          rstate_d = R_IDLE;
        end
      end
      default: begin
        rstate_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rstate_q  <= R_IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rbusy_q   <= 1'b0;
      rdone_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      rstate_q  <= rstate_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rbusy_q   <= rbusy_d;
      rdone_q   <= rdone_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_wbusy  = wbusy_q;
  assign mem_wdone  = wdone_q;
  assign mem_wresp  = wresp_q;
  assign awvalid    = awvalid_q;
  assign awaddr     = awaddr_q;
  assign awprot     = 3'b000;
  assign wvalid     = wvalid_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign bready     = bready_q;

  assign mem_rbusy  = rbusy_q;
  assign mem_rvalid = rdone_q;
  assign mem_rdata  = rdata_q;
  assign mem_rresp  = rresp_q;
  assign arvalid    = arvalid_q;
  assign araddr     = araddr_q;
  assign arprot     = 3'b000;
  assign rready     = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_2_axi4_lite.sv
`default_nettype none
// ============================================================================
// tb_mem_2_axi4_lite : bench for mem_2_axi4_lite with an AXI4-Lite slave model
// Revision           : 1.0
// ============================================================================
module tb_mem_2_axi4_lite;
  localparam int ALEN = 32;
  localparam int DLEN = 32;
  localparam int SLEN = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            mem_wen = 1'b0, mem_ren = 1'b0;
  logic [ALEN-1:0] mem_waddr = '0, mem_raddr = '0;
  logic [DLEN-1:0] mem_wdata = '0;
  logic [SLEN-1:0] mem_wstrb = '0;
  logic            mem_wbusy, mem_wdone, mem_rbusy, mem_rvalid;
  logic [1:0]      mem_wresp, mem_rresp;
  logic [DLEN-1:0] mem_rdata;
  logic            awvalid, wvalid, bready, arvalid, rready;
  logic            awready, wready, bvalid, arready, rvalid;
  logic [ALEN-1:0] awaddr, araddr;
  logic [2:0]      awprot, arprot;
  logic [DLEN-1:0] wdata, rdata;
  logic [SLEN-1:0] wstrb;
  logic [1:0]      bresp, rresp;

  mem_2_axi4_lite #(.ALEN(ALEN), .DLEN(DLEN), .SLEN(SLEN)) dut (
    .clk(clk), .rstn(rstn),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_wbusy(mem_wbusy), .mem_wdone(mem_wdone), .mem_wresp(mem_wresp),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rbusy(mem_rbusy),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;

  // slave behaviour knobs
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]      bresp_v = 2'b00, rresp_v = 2'b00;
  logic [DLEN-1:0] rdata_v = '0;

  // expected payload while valid is high, and monitor statistics
  logic [ALEN-1:0] exp_awaddr = '0, exp_araddr = '0;
  logic [DLEN-1:0] exp_wdata = '0;
  logic [SLEN-1:0] exp_wstrb = '0;
  int stab_err = 0;
  int n_aw = 0, n_w = 0, n_ar = 0, n_wdone = 0, n_rvalid = 0;
  int n_awv = 0, n_wv = 0, n_wbusy = 0;
  int aw_hs_cyc = 0, w_hs_cyc = 0, ar_hs_cyc = 0, wdone_cyc = 0, rvalid_cyc = 0;
  logic [ALEN-1:0] awaddr_seen = '0, araddr_seen = '0;
  logic [DLEN-1:0] wdata_seen = '0;
  logic [SLEN-1:0] wstrb_seen = '0;

  // scoreboard queues
  logic [1:0]      wq[$];
  logic [DLEN+1:0] rq[$];

  // slave model and completion monitor, all on the falling edge
  logic p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready;
  logic hs_aw, hs_w, hs_b, hs_ar, hs_r;
  logic got_aw, got_w, b_pend, r_pend;
  int   aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [1:0]      exp_wr;
  logic [DLEN+1:0] exp_rd;

  initial begin
    {p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready} = '0;
    {got_aw, got_w, b_pend, r_pend} = '0;
    {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
    {awready, wready, bvalid, arready, rvalid} = '0;
    bresp = 2'b00; rresp = 2'b00; rdata = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        {p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready} = '0;
        {got_aw, got_w, b_pend, r_pend} = '0;
        {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
        {awready, wready, bvalid, arready, rvalid} = '0;
      end else begin
        hs_aw = p_awvalid && awready;
        hs_w  = p_wvalid && wready;
        hs_b  = bvalid && p_bready;
        hs_ar = p_arvalid && arready;
        hs_r  = rvalid && p_rready;
        p_awvalid = awvalid; p_wvalid = wvalid; p_bready = bready;
        p_arvalid = arvalid; p_rready = rready;

        if (awvalid) begin
          n_awv++;
          if (awaddr !== exp_awaddr) stab_err++;
        end
        if (wvalid) begin
          n_wv++;
          if (wdata !== exp_wdata || wstrb !== exp_wstrb) stab_err++;
        end
        if (arvalid && araddr !== exp_araddr) stab_err++;

        if (hs_aw) begin
          awready = 1'b0; aw_cnt = 0; got_aw = 1'b1; n_aw++; aw_hs_cyc = cyc - 1;
        end else if (awvalid && !awready) begin
          if (aw_cnt >= aw_dly) begin awready = 1'b1; awaddr_seen = awaddr; end
          else aw_cnt++;
        end
        if (hs_w) begin
          wready = 1'b0; w_cnt = 0; got_w = 1'b1; n_w++; w_hs_cyc = cyc - 1;
        end else if (wvalid && !wready) begin
          if (w_cnt >= w_dly) begin wready = 1'b1; wdata_seen = wdata; wstrb_seen = wstrb; end
          else w_cnt++;
        end
        if (hs_b) bvalid = 1'b0;
        if (got_aw && got_w) begin b_pend = 1'b1; b_cnt = 0; got_aw = 1'b0; got_w = 1'b0; end
        if (b_pend && !bvalid) begin
          if (b_cnt >= b_dly) begin bvalid = 1'b1; bresp = bresp_v; b_pend = 1'b0; end
          else b_cnt++;
        end

        if (hs_ar) begin
          arready = 1'b0; ar_cnt = 0; r_pend = 1'b1; r_cnt = 0; n_ar++; ar_hs_cyc = cyc - 1;
        end else if (arvalid && !arready) begin
          if (ar_cnt >= ar_dly) begin arready = 1'b1; araddr_seen = araddr; end
          else ar_cnt++;
        end
        if (hs_r) rvalid = 1'b0;
        if (r_pend && !rvalid) begin
          if (r_cnt >= r_dly) begin rvalid = 1'b1; rdata = rdata_v; rresp = rresp_v; r_pend = 1'b0; end
          else r_cnt++;
        end
      end

      if (mem_wbusy) n_wbusy++;
      if (mem_wdone) begin
        n_wdone++; wdone_cyc = cyc; chk_cnt++;
        if (wq.size() == 0)
          $display("FAIL wdone_unexpected: got pulse with resp %0h, required no pulse", mem_wresp);
        else begin
          exp_wr = wq.pop_front();
          if (mem_wresp !== exp_wr) $display("FAIL wresp: got %0h, required %0h", mem_wresp, exp_wr);
          else pass_cnt++;
        end
      end
      if (mem_rvalid) begin
        n_rvalid++; rvalid_cyc = cyc; chk_cnt++;
        if (rq.size() == 0)
          $display("FAIL rvalid_unexpected: got pulse with data %0h, required no pulse", mem_rdata);
        else begin
          exp_rd = rq.pop_front();
          if ({mem_rdata, mem_rresp} !== exp_rd)
            $display("FAIL rdata_rresp: got %0h/%0h, required %0h/%0h",
                     mem_rdata, mem_rresp, exp_rd[DLEN+1:2], exp_rd[1:0]);
          else pass_cnt++;
        end
      end
    end
  end

  // caller is positioned on a falling edge; request is held for one cycle
  task automatic issue_write(input logic [ALEN-1:0] a, input logic [DLEN-1:0] d,
                             input logic [SLEN-1:0] s, input logic [1:0] er);
    mem_wen = 1'b1; mem_waddr = a; mem_wdata = d; mem_wstrb = s;
    exp_awaddr = a; exp_wdata = d; exp_wstrb = s;
    wq.push_back(er);
  endtask

  task automatic issue_read(input logic [ALEN-1:0] a, input logic [DLEN-1:0] ed, input logic [1:0] er);
    mem_ren = 1'b1; mem_raddr = a; exp_araddr = a;
    rq.push_back({ed, er});
  endtask

  task automatic wait_quiet(output logic to);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while ((wq.size() != 0 || rq.size() != 0 || mem_wbusy || mem_rbusy) && n < 200);
    to = (n >= 200);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({awvalid, wvalid, bready, arvalid, rready, mem_wbusy, mem_rbusy, mem_wdone, mem_rvalid} !== 9'b0)
      $display("FAIL reset_ctrl: got %b, required 0",
               {awvalid, wvalid, bready, arvalid, rready, mem_wbusy, mem_rbusy, mem_wdone, mem_rvalid});
    else pass_cnt++;
    chk_cnt++;
    if ({mem_wresp, mem_rresp} !== 4'b0) $display("FAIL reset_resp: got %b, required 0", {mem_wresp, mem_rresp});
    else pass_cnt++;
    chk_cnt++;
    if (mem_rdata !== '0) $display("FAIL reset_rdata: got %0h, required 0", mem_rdata);
    else pass_cnt++;
    chk_cnt++;
    if ({awprot, arprot} !== 6'b0) $display("FAIL prot: got %b, required 0", {awprot, arprot});
    else pass_cnt++;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_write();
    int req, b_wbusy, b_wdone;
    logic to;
    aw_dly = 0; w_dly = 0; b_dly = 0; bresp_v = 2'b00;
    b_wbusy = n_wbusy; b_wdone = n_wdone;
    @(negedge clk);
    issue_write(32'h10, 32'hDEADBEEF, 4'hF, 2'b00); req = cyc;
    @(negedge clk); mem_wen = 1'b0;
    wait_quiet(to); repeat (2) @(negedge clk);
    chk_cnt++; if (to) $display("FAIL basic_write_timeout: got timeout, required completion"); else pass_cnt++;
    chk_cnt++; if (aw_hs_cyc - req !== 1) $display("FAIL basic_aw_lat: got %0d, required 1", aw_hs_cyc - req); else pass_cnt++;
    chk_cnt++; if (w_hs_cyc - req !== 1) $display("FAIL basic_w_lat: got %0d, required 1", w_hs_cyc - req); else pass_cnt++;
    chk_cnt++; if (wdone_cyc - req !== 3) $display("FAIL basic_wdone_lat: got %0d, required 3", wdone_cyc - req); else pass_cnt++;
    chk_cnt++; if (n_wbusy - b_wbusy !== 2) $display("FAIL basic_wbusy_cycles: got %0d, required 2", n_wbusy - b_wbusy); else pass_cnt++;
    chk_cnt++; if (n_wdone - b_wdone !== 1) $display("FAIL basic_wdone_count: got %0d, required 1", n_wdone - b_wdone); else pass_cnt++;
    chk_cnt++;
    if ({awaddr_seen, wdata_seen, wstrb_seen} !== {32'h10, 32'hDEADBEEF, 4'hF})
      $display("FAIL basic_payload: got %0h %0h %0h, required 10 deadbeef f", awaddr_seen, wdata_seen, wstrb_seen);
    else pass_cnt++;
  endtask

  task automatic test_aw_skew();
    int req, b_awv, b_wv, b_wdone, b_stab;
    logic to;
    aw_dly = 3; w_dly = 0; b_dly = 0; bresp_v = 2'b10;
    b_awv = n_awv; b_wv = n_wv; b_wdone = n_wdone; b_stab = stab_err;
    @(negedge clk);
    issue_write(32'h100, 32'hA5A55A5A, 4'h3, 2'b10); req = cyc;
    @(negedge clk); mem_wen = 1'b0;
    wait_quiet(to); repeat (2) @(negedge clk);
    chk_cnt++; if (to) $display("FAIL awskew_timeout: got timeout, required completion"); else pass_cnt++;
    chk_cnt++; if (w_hs_cyc - req !== 1) $display("FAIL awskew_w_lat: got %0d, required 1", w_hs_cyc - req); else pass_cnt++;
    chk_cnt++; if (aw_hs_cyc - req !== 4) $display("FAIL awskew_aw_lat: got %0d, required 4", aw_hs_cyc - req); else pass_cnt++;
    chk_cnt++; if (n_wv - b_wv !== 1) $display("FAIL awskew_wvalid_cycles: got %0d, required 1", n_wv - b_wv); else pass_cnt++;
    chk_cnt++; if (n_awv - b_awv !== 4) $display("FAIL awskew_awvalid_cycles: got %0d, required 4", n_awv - b_awv); else pass_cnt++;
    chk_cnt++; if (stab_err !== b_stab) $display("FAIL awskew_stable: got %0d changes, required 0", stab_err - b_stab); else pass_cnt++;
    chk_cnt++; if (n_wdone - b_wdone !== 1) $display("FAIL awskew_wdone_count: got %0d, required 1", n_wdone - b_wdone); else pass_cnt++;
    chk_cnt++; if (wdone_cyc - req !== 6) $display("FAIL awskew_wdone_lat: got %0d, required 6", wdone_cyc - req); else pass_cnt++;
  endtask

  task automatic test_w_skew_busy();
    int req, b_aw, b_w, b_awv, b_wv, b_wdone, b_stab;
    logic to;
    aw_dly = 0; w_dly = 4; b_dly = 0; bresp_v = 2'b00;
    b_aw = n_aw; b_w = n_w; b_awv = n_awv; b_wv = n_wv; b_wdone = n_wdone; b_stab = stab_err;
    @(negedge clk);
    issue_write(32'h200, 32'h0BADF00D, 4'hC, 2'b00); req = cyc;
    @(negedge clk); mem_wen = 1'b0;
    // second request while busy must be dropped
    @(negedge clk);
    mem_wen = 1'b1; mem_waddr = 32'h300; mem_wdata = 32'h11111111; mem_wstrb = 4'h1;
    @(negedge clk); mem_wen = 1'b0;
    wait_quiet(to); repeat (4) @(negedge clk);
    chk_cnt++; if (to) $display("FAIL wskew_timeout: got timeout, required completion"); else pass_cnt++;
    chk_cnt++; if (n_aw - b_aw !== 1) $display("FAIL wskew_aw_count: got %0d, required 1", n_aw - b_aw); else pass_cnt++;
    chk_cnt++; if (n_w - b_w !== 1) $display("FAIL wskew_w_count: got %0d, required 1", n_w - b_w); else pass_cnt++;
    chk_cnt++; if (n_awv - b_awv !== 1) $display("FAIL wskew_awvalid_cycles: got %0d, required 1", n_awv - b_awv); else pass_cnt++;
    chk_cnt++; if (n_wv - b_wv !== 5) $display("FAIL wskew_wvalid_cycles: got %0d, required 5", n_wv - b_wv); else pass_cnt++;
    chk_cnt++; if (n_wdone - b_wdone !== 1) $display("FAIL wskew_wdone_count: got %0d, required 1", n_wdone - b_wdone); else pass_cnt++;
    chk_cnt++; if (wdone_cyc - req !== 7) $display("FAIL wskew_wdone_lat: got %0d, required 7", wdone_cyc - req); else pass_cnt++;
    chk_cnt++; if (awaddr_seen !== 32'h200) $display("FAIL wskew_awaddr: got %0h, required 200", awaddr_seen); else pass_cnt++;
    chk_cnt++; if (stab_err !== b_stab) $display("FAIL wskew_stable: got %0d changes, required 0", stab_err - b_stab); else pass_cnt++;
  endtask

  task automatic test_read();
    int req, b_rv;
    logic to;
    ar_dly = 0; r_dly = 2; rdata_v = 32'h12345678; rresp_v = 2'b10;
    b_rv = n_rvalid;
    @(negedge clk);
    issue_read(32'h20, 32'h12345678, 2'b10); req = cyc;
    @(negedge clk); mem_ren = 1'b0;
    wait_quiet(to); repeat (5) @(negedge clk);
    chk_cnt++; if (to) $display("FAIL read_timeout: got timeout, required completion"); else pass_cnt++;
    chk_cnt++; if (ar_hs_cyc - req !== 1) $display("FAIL read_ar_lat: got %0d, required 1", ar_hs_cyc - req); else pass_cnt++;
    chk_cnt++; if (rvalid_cyc - req !== 5) $display("FAIL read_rvalid_lat: got %0d, required 5", rvalid_cyc - req); else pass_cnt++;
    chk_cnt++; if (n_rvalid - b_rv !== 1) $display("FAIL read_pulse_count: got %0d, required 1", n_rvalid - b_rv); else pass_cnt++;
    chk_cnt++; if (araddr_seen !== 32'h20) $display("FAIL read_araddr: got %0h, required 20", araddr_seen); else pass_cnt++;
    chk_cnt++;
    if ({mem_rdata, mem_rresp, mem_rvalid} !== {32'h12345678, 2'b10, 1'b0})
      $display("FAIL read_hold: got %0h/%0h/%0b, required 12345678/2/0", mem_rdata, mem_rresp, mem_rvalid);
    else pass_cnt++;
  endtask

  task automatic test_concurrent();
    int req, b_wd, b_rv;
    logic to;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    bresp_v = 2'b11; rdata_v = 32'hCAFEF00D; rresp_v = 2'b01;
    b_wd = n_wdone; b_rv = n_rvalid;
    @(negedge clk);
    issue_write(32'h0, 32'h55AA33CC, 4'hF, 2'b11);
    issue_read(32'h4, 32'hCAFEF00D, 2'b01); req = cyc;
    @(negedge clk); mem_wen = 1'b0; mem_ren = 1'b0;
    wait_quiet(to); repeat (2) @(negedge clk);
    chk_cnt++; if (to) $display("FAIL conc_timeout: got timeout, required completion"); else pass_cnt++;
    chk_cnt++; if (wdone_cyc - req !== 3) $display("FAIL conc_wdone_lat: got %0d, required 3", wdone_cyc - req); else pass_cnt++;
    chk_cnt++; if (rvalid_cyc - req !== 3) $display("FAIL conc_rvalid_lat: got %0d, required 3", rvalid_cyc - req); else pass_cnt++;
    chk_cnt++;
    if (n_wdone - b_wd !== 1 || n_rvalid - b_rv !== 1)
      $display("FAIL conc_pulses: got %0d/%0d, required 1/1", n_wdone - b_wd, n_rvalid - b_rv);
    else pass_cnt++;
    chk_cnt++;
    if (awaddr_seen !== 32'h0 || araddr_seen !== 32'h4)
      $display("FAIL conc_addr: got %0h/%0h, required 0/4", awaddr_seen, araddr_seen);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int req, b_aw, b_wd, n;
    logic to;
    aw_dly = 0; w_dly = 0; b_dly = 0; bresp_v = 2'b00;
    b_aw = n_aw; b_wd = n_wdone;
    @(negedge clk);
    issue_write(32'h40, $urandom, 4'hF, 2'b00); req = cyc;
    for (int k = 1; k < 3; k++) begin
      @(negedge clk); mem_wen = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!mem_wdone && n < 20);
      issue_write(32'h40 + 32'(4 * k), $urandom, 4'hF, 2'b00);
    end
    @(negedge clk); mem_wen = 1'b0;
    wait_quiet(to); repeat (2) @(negedge clk);
    chk_cnt++; if (to) $display("FAIL b2b_timeout: got timeout, required completion"); else pass_cnt++;
    chk_cnt++; if (n_aw - b_aw !== 3) $display("FAIL b2b_aw_count: got %0d, required 3", n_aw - b_aw); else pass_cnt++;
    chk_cnt++; if (n_wdone - b_wd !== 3) $display("FAIL b2b_wdone_count: got %0d, required 3", n_wdone - b_wd); else pass_cnt++;
    chk_cnt++; if (wdone_cyc - req !== 9) $display("FAIL b2b_last_lat: got %0d, required 9", wdone_cyc - req); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int b_wd, b_rv;
    logic to;
    aw_dly = 20; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 20;
    bresp_v = 2'b00; rdata_v = 32'h77777777; rresp_v = 2'b00;
    b_wd = n_wdone; b_rv = n_rvalid;
    @(negedge clk);
    issue_write(32'h80, 32'h99999999, 4'hF, 2'b00);
    issue_read(32'h84, 32'h77777777, 2'b00);
    @(negedge clk); mem_wen = 1'b0; mem_ren = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({awvalid, wvalid, rready} !== 3'b101)
      $display("FAIL midrst_pre_state: got %b, required 101", {awvalid, wvalid, rready});
    else pass_cnt++;
    rstn = 1'b0; wq.delete(); rq.delete();
    @(negedge clk);
    chk_cnt++;
    if ({awvalid, wvalid, bready, arvalid, rready, mem_wbusy, mem_rbusy, mem_wdone, mem_rvalid} !== 9'b0)
      $display("FAIL midrst_ctrl: got %b, required 0",
               {awvalid, wvalid, bready, arvalid, rready, mem_wbusy, mem_rbusy, mem_wdone, mem_rvalid});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rstn = 1'b1; aw_dly = 0; r_dly = 0;
    repeat (5) @(negedge clk);
    chk_cnt++;
    if (n_wdone - b_wd !== 0 || n_rvalid - b_rv !== 0)
      $display("FAIL midrst_no_pulse: got %0d/%0d, required 0/0", n_wdone - b_wd, n_rvalid - b_rv);
    else pass_cnt++;
    b_wd = n_wdone; b_rv = n_rvalid;
    issue_write(32'h88, 32'h13572468, 4'h5, 2'b00);
    issue_read(32'h8C, 32'h77777777, 2'b00);
    @(negedge clk); mem_wen = 1'b0; mem_ren = 1'b0;
    wait_quiet(to); repeat (2) @(negedge clk);
    chk_cnt++; if (to) $display("FAIL midrst_after_timeout: got timeout, required completion"); else pass_cnt++;
    chk_cnt++;
    if (n_wdone - b_wd !== 1 || n_rvalid - b_rv !== 1)
      $display("FAIL midrst_after_pulses: got %0d/%0d, required 1/1", n_wdone - b_wd, n_rvalid - b_rv);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_aw_skew();
    test_w_skew_busy();
    test_read();
    test_concurrent();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
